// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory with registered read return.
// Define DM_ARB_LOCK_EN to let a port hold consecutive grants (up to LOCK_MAX) via its lock input.
module dm_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int LOCK_MAX   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [DM_ADDRESS-1:0] p0_addr,
    input  logic [DATA_W-1:0]     p0_wdata,
    input  logic                  p0_lock,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_W-1:0]     p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [DM_ADDRESS-1:0] p1_addr,
    input  logic [DATA_W-1:0]     p1_wdata,
    input  logic                  p1_lock,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_W-1:0]     p1_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_a,
    output logic [DATA_W-1:0]     mem_wd,
    input  logic [DATA_W-1:0]     mem_rd
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    arb_state_e         state_q, state_d;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic               last_q, last_d;
    logic               p0_rvalid_q, p0_rvalid_d;
    logic               p1_rvalid_q, p1_rvalid_d;
    logic [DATA_W-1:0]  p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0]  p1_rdata_q, p1_rdata_d;
    logic               win0;

    // win0: port 0 takes a tie; last_q=1 means port 1 was granted most recently
    always_comb begin
        win0 = last_q;
`ifdef DM_ARB_LOCK_EN
        if (state_q == LOCK0) begin
            win0 = 1'b1;
        end else if (state_q == LOCK1) begin
            win0 = 1'b0;
        end
`endif
        p0_gnt = reset_n & p0_req & (~p1_req | win0);
        p1_gnt = reset_n & p1_req & (~p0_req | ~win0);
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_a     = '0;
        mem_wd    = '0;
        if (p0_gnt) begin
            mem_read  = ~p0_we;
            mem_write = p0_we;
            mem_a     = p0_addr;
            mem_wd    = p0_wdata;
        end else if (p1_gnt) begin
            mem_read  = ~p1_we;
            mem_write = p1_we;
            mem_a     = p1_addr;
            mem_wd    = p1_wdata;
        end
    end

    always_comb begin
        last_d = last_q;
        if (p0_gnt) begin
            last_d = 1'b0;
        end else if (p1_gnt) begin
            last_d = 1'b1;
        end

        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
`ifdef DM_ARB_LOCK_EN
        case (state_q)
            ARB: begin
                if (p0_gnt && p0_lock && LOCK_MAX > 1) begin
                    state_d    = LOCK0;
                    lock_cnt_d = CNT_W'(1);
                end else if (p1_gnt && p1_lock && LOCK_MAX > 1) begin
                    state_d    = LOCK1;
                    lock_cnt_d = CNT_W'(1);
                end
            end
            LOCK0: begin
                if (!p0_gnt || !p0_lock || (lock_cnt_q + 1'b1) >= CNT_W'(LOCK_MAX)) begin
                    state_d    = ARB;
                    lock_cnt_d = '0;
                    if (!p1_gnt) begin
                        last_d = 1'b0;
                    end
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            LOCK1: begin
                if (!p1_gnt || !p1_lock || (lock_cnt_q + 1'b1) >= CNT_W'(LOCK_MAX)) begin
                    state_d    = ARB;
                    lock_cnt_d = '0;
                    if (!p0_gnt) begin
                        last_d = 1'b1;
                    end
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = ARB;
                lock_cnt_d = '0;
            end
        endcase
`else
        state_d    = ARB;
        lock_cnt_d = '0;
`endif

        p0_rvalid_d = p0_gnt & ~p0_we;
        p1_rvalid_d = p1_gnt & ~p1_we;
        p0_rdata_d  = p0_rvalid_d ? mem_rd : p0_rdata_q;
        p1_rdata_d  = p1_rvalid_d ? mem_rd : p1_rdata_q;
    end

`ifndef DM_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^{p0_lock, p1_lock, state_q, lock_cnt_q};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ARB;
            lock_cnt_q  <= '0;
            last_q      <= 1'b1;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            lock_cnt_q  <= lock_cnt_d;
            last_q      <= last_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
        end
    end

    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural single-port memory on the mem_* side.
// Expected lock-test grants follow DM_ARB_LOCK_EN when it is defined for the build.
module tb_dm_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          p0_req, p0_we, p0_lock, p0_gnt, p0_rvalid;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic          p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd, mem_rd;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_fails  = 0;

    logic [5:0] exp_lock_g0;

    always #5 clk = ~clk;

    dm_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .LOCK_MAX(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_lock(p0_lock), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    // Memory read data is combinational in the read-enable cycle; writes land on the edge.
    assign mem_rd = mem[mem_a];
    always @(posedge clk) begin
        if (mem_write) mem[mem_a] <= mem_wd;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef DM_ARB_LOCK_EN
        exp_lock_g0 = 6'b101111;
`else
        exp_lock_g0 = 6'b010101;
`endif
        reset_n = 1'b0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0; p0_lock = 1'b0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_lock = 1'b0;

        #2;
        check_val("rst_p0_gnt",    p0_gnt, 0);
        check_val("rst_mem_read",  mem_read, 0);
        check_val("rst_p0_rvalid", p0_rvalid, 0);
        check_val("rst_p0_rdata",  p0_rdata, 0);
        check_val("rst_p1_rdata",  p1_rdata, 0);
        @(negedge clk);
        reset_n = 1'b1;
        p0_req  = 1'b0;
        tick();

        // port 0 write then read back
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 9'd5; p0_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check_val("wr_p0_gnt",    p0_gnt, 1);
        check_val("wr_p1_gnt",    p1_gnt, 0);
        check_val("wr_mem_write", mem_write, 1);
        check_val("wr_mem_read",  mem_read, 0);
        check_val("wr_mem_a",     mem_a, 5);
        check_val("wr_mem_wd",    mem_wd, 32'hDEADBEEF);
        tick();
        p0_we = 1'b0; p0_wdata = '0;
        @(negedge clk);
        check_val("rd_p0_gnt",    p0_gnt, 1);
        check_val("rd_mem_read",  mem_read, 1);
        check_val("rd_mem_write", mem_write, 0);
        check_val("rd_mem_a",     mem_a, 5);
        check_val("wr_no_rvalid", p0_rvalid, 0);
        tick();
        p0_req = 1'b0;
        @(negedge clk);
        check_val("rd_p0_rvalid", p0_rvalid, 1);
        check_val("rd_p0_rdata",  p0_rdata, 32'hDEADBEEF);
        check_val("idle_p0_gnt",  p0_gnt, 0);
        check_val("idle_mem_read", mem_read, 0);
        check_val("idle_mem_a",   mem_a, 0);
        check_val("idle_mem_wd",  mem_wd, 0);
        tick();
        @(negedge clk);
        check_val("hold_p0_rvalid", p0_rvalid, 0);
        check_val("hold_p0_rdata",  p0_rdata, 32'hDEADBEEF);
        tick();

        // port 1 alone at the top address
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 9'h1FF; p1_wdata = 32'h12345678;
        @(negedge clk);
        check_val("p1wr_gnt",    p1_gnt, 1);
        check_val("p1wr_p0_gnt", p0_gnt, 0);
        check_val("p1wr_mem_a",  mem_a, 9'h1FF);
        check_val("p1wr_mem_wd", mem_wd, 32'h12345678);
        tick();
        p1_we = 1'b0;
        @(negedge clk);
        check_val("p1rd_gnt",      p1_gnt, 1);
        check_val("p1rd_mem_read", mem_read, 1);
        tick();
        p1_req = 1'b0;
        @(negedge clk);
        check_val("p1rd_rvalid",    p1_rvalid, 1);
        check_val("p1rd_rdata",     p1_rdata, 32'h12345678);
        check_val("p1rd_p0_rvalid", p0_rvalid, 0);
        tick();

        // preload data for the contention tests
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 9'd10; p0_wdata = 32'hA0A0A0A0;
        tick();
        p0_req = 1'b0;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 9'd20; p1_wdata = 32'hB1B1B1B1;
        tick();
        p1_req = 1'b0; p0_we = 1'b0; p1_we = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // continuous contention alternates, port 0 first after reset
        p0_req = 1'b1; p1_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_val($sformatf("rr_p0_gnt%0d", k), p0_gnt, (k % 2 == 0));
            check_val($sformatf("rr_p1_gnt%0d", k), p1_gnt, (k % 2 == 1));
            if (k > 0) begin
                check_val($sformatf("rr_p0_rvalid%0d", k), p0_rvalid, (k % 2 == 1));
                check_val($sformatf("rr_p1_rvalid%0d", k), p1_rvalid, (k % 2 == 0));
                if (k % 2 == 1) check_val($sformatf("rr_p0_rdata%0d", k), p0_rdata, 32'hA0A0A0A0);
                else            check_val($sformatf("rr_p1_rdata%0d", k), p1_rdata, 32'hB1B1B1B1);
            end
            tick();
        end
        p0_req = 1'b0; p1_req = 1'b0;
        @(negedge clk);
        check_val("rr_last_p1_rvalid", p1_rvalid, 1);
        check_val("rr_last_p1_rdata",  p1_rdata, 32'hB1B1B1B1);
        tick();

        // port 0 holds lock under contention
        p0_req = 1'b1; p1_req = 1'b1; p0_lock = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_val($sformatf("lock_p0_gnt%0d", k), p0_gnt, exp_lock_g0[k]);
            check_val($sformatf("lock_p1_gnt%0d", k), p1_gnt, !exp_lock_g0[k]);
            tick();
        end
        p0_req = 1'b0; p1_req = 1'b0; p0_lock = 1'b0;
        tick();
        tick();

        // reset in the middle of a port 0 read grant
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 9'd5;
        @(negedge clk);
        check_val("mid_pre_gnt",  p0_gnt, 1);
        check_val("mid_pre_read", mem_read, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("mid_p0_gnt",    p0_gnt, 0);
        check_val("mid_p1_gnt",    p1_gnt, 0);
        check_val("mid_mem_read",  mem_read, 0);
        check_val("mid_mem_a",     mem_a, 0);
        check_val("mid_p0_rvalid", p0_rvalid, 0);
        check_val("mid_p0_rdata",  p0_rdata, 0);
        @(negedge clk);
        reset_n = 1'b1;
        p0_req  = 1'b0;
        tick();
        check_val("post_rst_rvalid", p0_rvalid, 0);
        p0_req = 1'b1; p1_req = 1'b1; p1_addr = 9'd20;
        @(negedge clk);
        check_val("post_rst_tie_p0", p0_gnt, 1);
        check_val("post_rst_tie_p1", p1_gnt, 0);
        tick();
        p0_req = 1'b0; p1_req = 1'b0;
        @(negedge clk);
        check_val("post_rst_rvalid2", p0_rvalid, 1);
        check_val("post_rst_rdata",   p0_rdata, 32'hDEADBEEF);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter DM_ADDRESS, default 9, SHALL set the word-address width of both ports and the memory side.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width of both ports and the memory side.
REQ-003 Parameter LOCK_MAX, default 4, SHALL set the maximum number of consecutive locked grants to one port.
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 pN_req  in  1  (N=0,1) SHALL be the access request of port N.
REQ-007 pN_we  in  1  SHALL select write (1) or read (0) for port N.
REQ-008 pN_addr  in  DM_ADDRESS  SHALL be the word address of port N.
REQ-009 pN_wdata  in  DATA_W  SHALL be the write data of port N.
REQ-010 pN_lock  in  1  SHALL request lock retention for port N; it is ignored unless DM_ARB_LOCK_EN is defined.
REQ-011 pN_gnt  out  1  SHALL indicate that port N's access executes this cycle.
REQ-012 pN_rvalid  out  1  SHALL mark valid read data on pN_rdata.
REQ-013 pN_rdata  out  DATA_W  SHALL carry port N's read data.
REQ-014 mem_read, mem_write  out  1 each  SHALL drive the memory's read and write enables.
REQ-015 mem_a  out  DM_ADDRESS; mem_wd  out  DATA_W  SHALL drive the memory address and write data.
REQ-016 mem_rd  in  DATA_W  SHALL carry the memory read data, valid in the same cycle as mem_read.

Function
REQ-017 Handshake: a requester SHALL hold req, we, addr and wdata stable until gnt; an access transfers in a cycle where req and gnt are both 1.
REQ-018 At most one of p0_gnt and p1_gnt SHALL be 1 in any cycle; gnt SHALL be combinational from req and the registered arbitration state.
REQ-019 If only one port requests, that port SHALL be granted in the same cycle.
REQ-020 If both ports request and no lock is active, the port not granted most recently SHALL be granted (round-robin). The last-grant pointer SHALL update on every grant.
REQ-021 In a granted cycle, mem_a and mem_wd SHALL equal the granted port's addr and wdata, mem_write SHALL equal its we, and mem_read SHALL equal its inverted we.
REQ-022 In a cycle with no grant, mem_read, mem_write, mem_a and mem_wd SHALL all be 0.
REQ-023 Write latency: memory SHALL be written at the rising edge ending the grant cycle; no rvalid SHALL be raised for writes.
REQ-024 Read latency: mem_rd SHALL be registered into pN_rdata at the edge ending the grant cycle. pN_rvalid SHALL be 1 for exactly the following cycle.
REQ-025 pN_rdata SHALL hold its last value while pN_rvalid is 0.
REQ-026 Back-to-back grants to the same or to alternating ports SHALL be sustained at one access per cycle with no bubbles.
REQ-027 A request dropped before its grant SHALL be discarded with no memory side effect.

Reset
REQ-028 Asserting reset_n low SHALL clear the following immediately, regardless of clk: the last-grant pointer to 1 (port 0 wins the first tie), the FSM to ARB, the lock counter to 0, both rvalid outputs to 0 and both rdata outputs to 0.
REQ-029 A read granted in the cycle reset asserts SHALL produce no rvalid after reset releases.
REQ-030 gnt and all mem_* outputs SHALL be 0 while reset_n is low.

Configuration
REQ-031 With DM_ARB_LOCK_EN defined, the FSM SHALL have states ARB, LOCK0 and LOCK1:
- ARB -> LOCKn when port n is granted with pn_lock=1; the lock counter is set to 1.
- In LOCKn, port n SHALL have absolute priority whenever it requests; each locked grant increments the counter.
- LOCKn -> ARB when port n is granted with pn_lock=0, when port n does not request in a cycle, or when the counter reaches LOCK_MAX. On that exit the pointer SHALL mark port n as last granted.
REQ-032 Without DM_ARB_LOCK_EN, the FSM SHALL remain in ARB, the lock inputs SHALL be ignored and arbitration SHALL be pure round-robin.

Verification
REQ-033 Port 0 write addr 5 data 0xDEADBEEF, then port 0 read addr 5 -> p0_gnt in both cycles; p0_rvalid=1 with p0_rdata=0xDEADBEEF one cycle after the read grant.
REQ-034 Both ports request reads continuously for 6 cycles after reset -> grants alternate p0,p1,p0,p1,p0,p1; each rvalid follows its grant by 1 cycle.
REQ-035 Port 1 only, read addr 0x1FF after a write of 0x12345678 -> same-cycle grant; p1_rdata=0x12345678.
REQ-036 With DM_ARB_LOCK_EN and LOCK_MAX=4: both ports request and port 0 holds lock=1 -> p0 granted 4 cycles, then p1 granted. Without the macro -> grants alternate.
REQ-037 reset_n asserted low mid-cycle during a port-0 read grant -> p0_rvalid=0, both gnt=0 and mem_read=0 immediately; after release, a tie grants port 0.
